// File: rtl/pc_gen.sv
// Program-counter generator feeding the instruction fetch stage.
// Advances sequentially and redirects on branches and flushes, with pending redirects held while a fetch is in flight.
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_stall,
  input  logic        pipe_stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        flush,
  input  logic [31:0] new_pc,
  output logic [31:0] pc,
  output logic        ce,
  output logic        in_delay_slot
);

  typedef enum logic {
    ST_RUN        = 1'b0,
    ST_WAIT_REDIR = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_pending_target;
  logic [31:0] w_pending_target_nxt;
  logic        r_ce;
  logic        w_pending_valid;
  logic        w_adv;

  // Handshake: the fetch at pc is consumed only when ce is set, fetch has
  // returned data (~fetch_stall) and downstream accepts it (~pipe_stall);
  // pc must stay stable on every other cycle unless a flush overrides it.
  assign w_adv           = r_ce & ~fetch_stall & ~pipe_stall;
  assign w_pending_valid = (r_state == ST_WAIT_REDIR);

  always_comb begin
    w_state_nxt          = r_state;
    w_pc_nxt             = r_pc;
    w_pending_target_nxt = r_pending_target;
    if (flush) begin
      w_pc_nxt    = new_pc;
      w_state_nxt = ST_RUN;
    end else if (w_pending_valid) begin
      // A branch seen here sits in a delay slot; the first target wins.
      if (w_adv) begin
        w_pc_nxt    = r_pending_target;
        w_state_nxt = ST_RUN;
      end
    end else if (branch_flag) begin
      if (w_adv) begin
        w_pc_nxt = branch_target;
      end else begin
        w_pending_target_nxt = branch_target;
        w_state_nxt          = ST_WAIT_REDIR;
      end
    end else if (w_adv) begin
      w_pc_nxt = r_pc + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_RUN;
      r_pc             <= RESET_PC;
      r_pending_target <= 32'd0;
      r_ce             <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_pc             <= w_pc_nxt;
      r_pending_target <= w_pending_target_nxt;
      r_ce             <= 1'b1;
    end
  end

  assign pc            = r_pc;
  assign ce            = r_ce;
  assign in_delay_slot = ~flush & (w_pending_valid | branch_flag);

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed scenarios then random traffic, checked
// against a reference model that keeps outstanding redirects in a queue.
module tb_pc_gen;

  localparam int W = 34;
  localparam logic [31:0] RST_PC = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_stall;
  logic        pipe_stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] pc;
  logic        ce;
  logic        in_delay_slot;

  logic [W-1:0] exp_q[$];
  logic [31:0]  m_pend_q[$];
  logic [31:0]  m_pc;
  logic         m_ce;
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;

  pc_gen dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_stall   (fetch_stall),
    .pipe_stall    (pipe_stall),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .flush         (flush),
    .new_pc        (new_pc),
    .pc            (pc),
    .ce            (ce),
    .in_delay_slot (in_delay_slot)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Reference model: one clock edge worth of architectural rules.
  task automatic model_edge(input logic r, input logic fs, input logic ps,
                            input logic bf, input logic [31:0] bt,
                            input logic fl, input logic [31:0] np);
    logic adv;
    if (r) begin
      m_pc = RST_PC;
      m_ce = 1'b0;
      m_pend_q.delete();
    end else begin
      adv = m_ce && !fs && !ps;
      if (fl) begin
        m_pc = np;
        m_pend_q.delete();
      end else if (m_pend_q.size() != 0) begin
        if (adv) m_pc = m_pend_q.pop_front();
      end else if (bf) begin
        if (adv) m_pc = bt;
        else m_pend_q.push_back(bt);
      end else if (adv) begin
        m_pc = m_pc + 32'd4;
      end
      m_ce = 1'b1;
    end
  endtask

  // driver: apply one cycle of inputs, queue expected outputs, step model
  task automatic drive(input logic r, input logic fs, input logic ps,
                       input logic bf, input logic [31:0] bt,
                       input logic fl, input logic [31:0] np);
    logic ds;
    @(negedge clk);
    rst = r; fetch_stall = fs; pipe_stall = ps;
    branch_flag = bf; branch_target = bt; flush = fl; new_pc = np;
    ds = !fl && ((m_pend_q.size() != 0) || bf);
    exp_q.push_back({m_pc, m_ce, ds});
    model_edge(r, fs, ps, bf, bt, fl, np);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    #1;
    cyc++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (pc !== e[33:2]) begin
        n_fail++;
        $display("FAIL pc cyc=%0d got=%08h exp=%08h", cyc, pc, e[33:2]);
      end
      n_tests++;
      if (ce !== e[1]) begin
        n_fail++;
        $display("FAIL ce cyc=%0d got=%0b exp=%0b", cyc, ce, e[1]);
      end
      n_tests++;
      if (in_delay_slot !== e[0]) begin
        n_fail++;
        $display("FAIL in_delay_slot cyc=%0d got=%0b exp=%0b", cyc, in_delay_slot, e[0]);
      end
    end
  end

  initial begin
    logic r, fs, ps, bf, fl;
    logic [31:0] bt, np;
    rst = 1'b1; fetch_stall = 0; pipe_stall = 0; branch_flag = 0;
    branch_target = 0; flush = 0; new_pc = 0;
    repeat (2) @(posedge clk);
    model_edge(1, 0, 0, 0, 32'h0, 0, 32'h0);

    // 1: reset held, then release and sequential advance to BFC00010
    drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
    idle(5);
    // 2: fetch stall for 3 cycles, then advance to BFC00020
    repeat (3) drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
    idle(4);
    // 3: branch with no stall
    drive(0, 0, 0, 1, 32'h80001000, 0, 32'h0);
    idle(2);
    // 4: branch under stall, second branch in delay slot ignored
    drive(0, 1, 0, 1, 32'h80002000, 0, 32'h0);
    drive(0, 1, 0, 1, 32'h00009000, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
    idle(2);
    // 5: pending branch killed by flush under pipe stall
    drive(0, 0, 1, 1, 32'h80003000, 0, 32'h0);
    drive(0, 0, 1, 0, 32'h0, 1, 32'hBFC00380);
    idle(3);
    // 6: wrap at top of address space, then reset while pending
    drive(0, 0, 0, 1, 32'hFFFFFFFC, 0, 32'h0);
    idle(2);
    drive(0, 1, 0, 1, 32'h80004000, 0, 32'h0);
    drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
    idle(3);
    // pipe_stall alone also holds pc; flush wins over a same-cycle branch
    repeat (2) drive(0, 0, 1, 0, 32'h0, 0, 32'h0);
    drive(0, 0, 0, 1, 32'h80005000, 1, 32'h80000180);
    idle(2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      fs = ($urandom_range(0, 2) == 0);
      ps = ($urandom_range(0, 3) == 0);
      bf = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 15) == 0);
      bt = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
      np = $urandom;
      drive(r, fs, ps, bf, bt, fl, np);
    end
    idle(2);

    repeat (3) @(negedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d left exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
